// File: rtl/imem_responder_if.sv
// Fetch-side instruction request/response bus between fetch and the instruction memory.
interface imem_responder_if;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;
   logic        iresp_err;

   modport master (
      output ireq_valid,
      output ireq_addr,
      input  iresp_data_ok,
      input  iresp_data,
      input  iresp_err
   );

   modport slave (
      input  ireq_valid,
      input  ireq_addr,
      output iresp_data_ok,
      output iresp_data,
      output iresp_err
   );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch at a time and returns the
// instruction word LATENCY cycles after acceptance, with a one-cycle data_ok pulse.
module imem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2,
   parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
   input  logic                           clk,
   input  logic                           reset,
   imem_responder_if.slave                bus,
   output logic                           busy,
   input  logic                           ld_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] ld_idx,
   input  logic [31:0]                    ld_data
);

   localparam int unsigned IdxW       = $clog2(DEPTH_WORDS);
   localparam logic [63:0] RangeBytes = 64'(DEPTH_WORDS) << 2;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [63:0]      addr_q, addr_d;
   logic [31:0]      data_q;
   logic             err_q;
   logic             load;

   logic [31:0]      mem [DEPTH_WORDS];

   logic [63:0]      dec_addr;
   logic [63:0]      off;
   logic [IdxW-1:0]  idx;
   logic             fault;
   logic [31:0]      rd_word;

   // Decode the address being loaded; in IDLE (LATENCY=1) it has not been latched yet.
   always_comb begin
      dec_addr = (state_q == StIdle) ? bus.ireq_addr : addr_q;
      off      = dec_addr - BASE_ADDR;
      idx      = off[IdxW+1:2];
      fault    = (dec_addr[1:0] != 2'b00) || (off >= RangeBytes);
      // Write-first bypass when the preload hits the word being returned.
      rd_word  = (ld_en && (ld_idx == idx)) ? ld_data : mem[idx];
   end

   // Next-state logic for the request FSM.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      load    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.ireq_valid) begin
               addr_d = bus.ireq_addr;
               cnt_d  = 4'(LATENCY - 1);
               if (LATENCY == 1) begin
                  state_d = StResp;
                  load    = 1'b1;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            if (!bus.ireq_valid) begin
               // Abandoned by a flush/redirect: no response.
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q <= 4'd1) begin
                  state_d = StResp;
                  load    = 1'b1;
               end
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // FSM, request and response registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         addr_q  <= 64'd0;
         data_q  <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         if (load) begin
            err_q  <= fault;
            data_q <= fault ? 32'h0 : rd_word;
         end
      end
   end

   // Backing store; deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (ld_en) begin
         mem[ld_idx] <= ld_data;
      end
   end

   // Response outputs; data/err hold between loads and are qualified by data_ok.
   always_comb begin
      bus.iresp_data_ok = (state_q == StResp);
      bus.iresp_data    = data_q;
      bus.iresp_err     = err_q;
      busy              = (state_q != StIdle);
   end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder with default parameters (LATENCY=2, 1024 words).
module tb_imem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        busy;
   logic        ld_en;
   logic [9:0]  ld_idx;
   logic [31:0] ld_data;

   int n_checks = 0;
   int n_fail   = 0;

   imem_responder_if bus ();

   imem_responder dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus.slave),
      .busy    (busy),
      .ld_en   (ld_en),
      .ld_idx  (ld_idx),
      .ld_data (ld_data)
   );

   always #5 clk = ~clk;

   // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [9:0] idx, input logic [31:0] data);
      ld_en   = 1'b1;
      ld_idx  = idx;
      ld_data = data;
      step();
      ld_en   = 1'b0;
   endtask

   task automatic test_reset();
      reset          = 1'b0;
      bus.ireq_valid = 1'b0;
      bus.ireq_addr  = 64'h0;
      ld_en          = 1'b0;
      ld_idx         = '0;
      ld_data        = '0;
      step();
      step();
      n_checks++;
      if (bus.iresp_data_ok !== 1'b0) begin
         n_fail++; $display("FAIL reset_data_ok: got %b want 0", bus.iresp_data_ok);
      end
      n_checks++;
      if (bus.iresp_data !== 32'h0) begin
         n_fail++; $display("FAIL reset_data: got %h want 00000000", bus.iresp_data);
      end
      n_checks++;
      if (bus.iresp_err !== 1'b0) begin
         n_fail++; $display("FAIL reset_err: got %b want 0", bus.iresp_err);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
      end
      reset = 1'b1;
      step();
   endtask

   // One full request with latency 2: checks spacing, payload and post-response hold.
   task automatic test_read(input string name, input logic [63:0] addr,
                            input logic [31:0] exp_data, input logic exp_err);
      bus.ireq_valid = 1'b1;
      bus.ireq_addr  = addr;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL %s_idle_busy: got %b want 0", name, busy);
      end
      step();
      // Changing the address while busy must not affect the response.
      bus.ireq_addr = 64'h8000_0004;
      n_checks++;
      if (bus.iresp_data_ok !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_wait: got ok=%b busy=%b want ok=0 busy=1", name,
                  bus.iresp_data_ok, busy);
      end
      step();
      n_checks++;
      if (bus.iresp_data_ok !== 1'b1) begin
         n_fail++; $display("FAIL %s_data_ok: got %b want 1", name, bus.iresp_data_ok);
      end
      n_checks++;
      if (bus.iresp_data !== exp_data || bus.iresp_err !== exp_err) begin
         n_fail++;
         $display("FAIL %s_resp: got data=%h err=%b want data=%h err=%b", name,
                  bus.iresp_data, bus.iresp_err, exp_data, exp_err);
      end
      bus.ireq_valid = 1'b0;
      step();
      n_checks++;
      if (bus.iresp_data_ok !== 1'b0 || busy !== 1'b0 || bus.iresp_data !== exp_data) begin
         n_fail++;
         $display("FAIL %s_after: got ok=%b busy=%b data=%h want ok=0 busy=0 data=%h", name,
                  bus.iresp_data_ok, busy, bus.iresp_data, exp_data);
      end
   endtask

   task automatic test_back_to_back();
      bus.ireq_valid = 1'b1;
      bus.ireq_addr  = 64'h8000_0000;
      step();
      step();
      n_checks++;
      if (bus.iresp_data_ok !== 1'b1 || bus.iresp_data !== 32'h0000_0013) begin
         n_fail++;
         $display("FAIL b2b_first: got ok=%b data=%h want ok=1 data=00000013",
                  bus.iresp_data_ok, bus.iresp_data);
      end
      // Valid stays high into the RESP cycle with the next address.
      bus.ireq_addr = 64'h8000_0004;
      step();
      n_checks++;
      if (bus.iresp_data_ok !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_accept: got ok=%b busy=%b want ok=0 busy=0",
                  bus.iresp_data_ok, busy);
      end
      step();
      n_checks++;
      if (bus.iresp_data_ok !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_wait: got ok=%b busy=%b want ok=0 busy=1", bus.iresp_data_ok, busy);
      end
      step();
      n_checks++;
      if (bus.iresp_data_ok !== 1'b1 || bus.iresp_data !== 32'h0010_0093) begin
         n_fail++;
         $display("FAIL b2b_second: got ok=%b data=%h want ok=1 data=00100093",
                  bus.iresp_data_ok, bus.iresp_data);
      end
      bus.ireq_valid = 1'b0;
      step();
   endtask

   task automatic test_abandon();
      bus.ireq_valid = 1'b1;
      bus.ireq_addr  = 64'h8000_0000;
      step();
      bus.ireq_valid = 1'b0;
      step();
      n_checks++;
      if (bus.iresp_data_ok !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abandon_drop: got ok=%b busy=%b want ok=0 busy=0",
                  bus.iresp_data_ok, busy);
      end
      bus.ireq_valid = 1'b1;
      bus.ireq_addr  = 64'h8000_0004;
      step();
      n_checks++;
      if (bus.iresp_data_ok !== 1'b0) begin
         n_fail++; $display("FAIL abandon_new_wait: got ok=%b want 0", bus.iresp_data_ok);
      end
      step();
      n_checks++;
      if (bus.iresp_data_ok !== 1'b1 || bus.iresp_data !== 32'h0010_0093) begin
         n_fail++;
         $display("FAIL abandon_new_resp: got ok=%b data=%h want ok=1 data=00100093",
                  bus.iresp_data_ok, bus.iresp_data);
      end
      bus.ireq_valid = 1'b0;
      step();
   endtask

   task automatic test_bypass();
      bus.ireq_valid = 1'b1;
      bus.ireq_addr  = 64'h8000_0008;
      step();
      ld_en   = 1'b1;
      ld_idx  = 10'd2;
      ld_data = 32'hDEAD_BEEF;
      step();
      ld_en = 1'b0;
      n_checks++;
      if (bus.iresp_data_ok !== 1'b1 || bus.iresp_data !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL bypass: got ok=%b data=%h want ok=1 data=deadbeef",
                  bus.iresp_data_ok, bus.iresp_data);
      end
      bus.ireq_valid = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      bus.ireq_valid = 1'b1;
      bus.ireq_addr  = 64'h8000_0004;
      step();
      reset = 1'b0;
      step();
      n_checks++;
      if (bus.iresp_data_ok !== 1'b0 || busy !== 1'b0 || bus.iresp_data !== 32'h0 ||
          bus.iresp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: got ok=%b busy=%b data=%h err=%b want all zero",
                  bus.iresp_data_ok, busy, bus.iresp_data, bus.iresp_err);
      end
      reset          = 1'b1;
      bus.ireq_valid = 1'b0;
      step();
      n_checks++;
      if (bus.iresp_data_ok !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_release: got ok=%b busy=%b want 0 0", bus.iresp_data_ok, busy);
      end
   endtask

   initial begin
      test_reset();
      preload(10'd0, 32'h0000_0013);
      preload(10'd1, 32'h0010_0093);
      preload(10'd2, 32'h0020_0113);
      preload(10'd1023, 32'hCAFE_0001);
      test_read("basic", 64'h8000_0000, 32'h0000_0013, 1'b0);
      test_read("word2", 64'h8000_0008, 32'h0020_0113, 1'b0);
      test_read("last_word", 64'h8000_0FFC, 32'hCAFE_0001, 1'b0);
      test_back_to_back();
      test_abandon();
      test_read("misaligned", 64'h8000_0002, 32'h0, 1'b1);
      test_read("out_of_range", 64'h8000_1000, 32'h0, 1'b1);
      test_read("below_base", 64'h7FFF_FFFC, 32'h0, 1'b1);
      test_bypass();
      test_read("after_bypass", 64'h8000_0008, 32'hDEAD_BEEF, 1'b0);
      test_reset_mid();
      test_read("mem_kept", 64'h8000_0000, 32'h0000_0013, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder for the fetch-side instruction request bus, i.e. the target of the PC that fetch issues.
- Accepts one fetch request at a time and returns a 32-bit instruction word after a fixed, parameterised latency.
- Asserts data_ok for exactly one cycle; a requester stalls on "valid & ~data_ok", which produces the Iwait condition.
- Used as the instruction backing store in simulation and for fetch-stage verification.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in storage; power of two.
- LATENCY, 2, cycles from request acceptance to data_ok; legal range 1..15.
- BASE_ADDR, 64'h8000_0000, byte address of word 0.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-low
- ireq_valid  in  1  fetch request valid; held high until data_ok or abandoned
- ireq_addr  in  64  fetch byte address
- iresp_data_ok  out  1  response valid, one-cycle pulse
- iresp_data  out  32  instruction word; valid only when data_ok=1
- iresp_err  out  1  access fault; valid only when data_ok=1
- busy  out  1  a request is in flight (state != IDLE)
- ld_en  in  1  backdoor preload write enable
- ld_idx  in  $clog2(DEPTH_WORDS)  backdoor word index
- ld_data  in  32  backdoor write data

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on the port named reset.
- Reset state: state=IDLE; iresp_data_ok=0, iresp_data=0, iresp_err=0, busy=0; counter=0.
- Reset asserted mid-request drops the request silently; no data_ok is produced.
- Storage contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - ireq_valid=1 in cycle T accepts the request: latch ireq_addr to req_addr and set counter=LATENCY-1.
  - If LATENCY=1, go straight to RESP; otherwise go to WAIT.
- WAIT:
  - ireq_valid=0 means the request was abandoned (flush/redirect). Return to IDLE next cycle; no response is produced.
  - Otherwise decrement counter. When counter reaches 0, load the response registers and enter RESP.
- RESP:
  - iresp_data_ok=1 for this single cycle.
  - Unconditionally return to IDLE.
  - A request still valid in the RESP cycle is not accepted that cycle. Earliest next acceptance is RESP+1, so back-to-back fetches are spaced LATENCY+1 cycles apart.
- Latency: data_ok is asserted in cycle T+LATENCY.
- ireq_addr changing while busy is a protocol violation. The responder ignores it and uses req_addr.
- Address decode, with off = req_addr - BASE_ADDR (64-bit wrap-around subtraction):
  - Fault if req_addr[1:0] != 0, or off >= DEPTH_WORDS*4 (unsigned; addresses below BASE_ADDR wrap to large values and therefore fault).
  - Index = off[$clog2(DEPTH_WORDS)+1:2].
- Response register load, on the WAIT->RESP transition (or IDLE->RESP when LATENCY=1):
  - iresp_err = fault.
  - iresp_data = fault ? 32'h0 : mem[index].
- iresp_data and iresp_err hold their value after RESP until the next load; consumers qualify them with data_ok.
- Backdoor preload:
  - ld_en writes mem[ld_idx] on the rising edge of clk, in any state.
  - If the write targets the pending index in the same cycle the response registers load, the new ld_data is returned (write-first bypass).
- busy = (state != IDLE).

Test Plan:
- Basic read, LATENCY=2: preload mem[0]=32'h0000_0013. Raise ireq_valid with addr 0x8000_0000 at cycle 10 -> data_ok=1 at cycle 12 only, data=0x00000013, err=0.
- Back-to-back: hold ireq_valid with addr 0x8000_0004 (mem[1]=0x00100093) after a response at cycle 12 -> accepted at cycle 13, data_ok at cycle 15, data=0x00100093.
- Abandon: request at cycle 10, drop ireq_valid at cycle 11 -> no data_ok at cycle 12. A new request at cycle 12 gets data_ok at cycle 14.
- Fault cases, each returning data_ok with err=1 and data=0:
  - addr 0x8000_0002 (misaligned);
  - addr 0x8000_1000 (DEPTH_WORDS=1024, out of range);
  - addr 0x7FFF_FFFC (below base).
- Bypass: request 0x8000_0008 at cycle 10 with ld_en=1, ld_idx=2, ld_data=0xDEADBEEF at cycle 11 -> data=0xDEADBEEF at cycle 12.
- Reset mid-request: request at cycle 10, reset=0 at cycle 11 -> no data_ok, busy=0 from cycle 12, outputs all zero. mem[0] still reads 0x00000013 on a later request.
